// File: rtl/prueba_i.sv
// Integral term of the servo PI controller: serial shift-add KI*e, scaled, saturating accumulate.
// Optional deadband on the error via macro PRUEBA_I_DEADBAND_EN.
module prueba_i #(
    parameter int                          cant_bits = 13,
    parameter logic signed [cant_bits-1:0] KI        = 13'sd8,
    parameter int                          KI_SHIFT  = 3,
    parameter int                          DEADBAND  = 2
) (
    input  logic                            Clk_G,
    input  logic                            Rst_G,
    input  logic                            Rx_En,
    input  logic signed [cant_bits-1:0]     Pot,
    input  logic signed [cant_bits-1:0]     Ref,
    output logic signed [2*cant_bits-1:0]   R_I
);
    localparam int W  = cant_bits;
    localparam int EW = W + 1;
    localparam int PW = 2 * W;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic signed [PW-1:0] KI_EXT = PW'(KI);
    localparam logic signed [PW+1:0] S_MAX = {3'b000, {(PW-1){1'b1}}};
    localparam logic signed [PW+1:0] S_MIN = {3'b111, {(PW-1){1'b0}}};
`ifdef PRUEBA_I_DEADBAND_EN
    localparam int DB_EFF = DEADBAND;
`else
    // A zero threshold only zeroes an already-zero error, so the datapath is identical.
    localparam int DB_EFF = 0 * DEADBAND;
`endif

    typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

    state_t                 state;
    logic [W-1:0]           e_mag;
    logic                   e_neg;
    logic signed [PW-1:0]   prod;
    logic [CW-1:0]          cnt;

    logic signed [EW-1:0]   diff;
    logic [EW-1:0]          diff_mag;
    logic                   db_hit;
    logic signed [PW:0]     p_mag;
    logic signed [PW:0]     p;
    logic signed [PW:0]     q;
    logic signed [PW+1:0]   s;
    logic signed [PW-1:0]   r_next;

    always_comb begin
        diff     = {Ref[W-1], Ref} - {Pot[W-1], Pot};
        diff_mag = diff[EW-1] ? EW'(-diff) : EW'(diff);
        db_hit   = (diff_mag <= EW'(DB_EFF));

        p_mag = {prod[PW-1], prod};
        p     = e_neg ? -p_mag : p_mag;
        q     = p >>> KI_SHIFT;
        s     = {{2{R_I[PW-1]}}, R_I} + {q[PW], q};
        if (s > S_MAX)
            r_next = S_MAX[PW-1:0];
        else if (s < S_MIN)
            r_next = S_MIN[PW-1:0];
        else
            r_next = s[PW-1:0];
    end

    always_ff @(posedge Clk_G or negedge Rst_G) begin
        if (!Rst_G) begin
            state <= IDLE;
            e_mag <= '0;
            e_neg <= 1'b0;
            prod  <= '0;
            cnt   <= '0;
            R_I   <= '0;
        end else begin
            case (state)
                IDLE: if (Rx_En) begin
                    e_mag <= db_hit ? '0 : diff_mag[W-1:0];
                    e_neg <= db_hit ? 1'b0 : diff[EW-1];
                    prod  <= '0;
                    cnt   <= '0;
                    state <= MUL;
                end
                MUL: begin
                    if (e_mag[cnt])
                        prod <= prod + (KI_EXT <<< cnt);
                    if (cnt == LAST)
                        state <= ACC;
                    else
                        cnt <= cnt + CW'(1);
                end
                ACC: begin
                    R_I   <= r_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prueba_i.sv
// Self-checking bench for prueba_i: two gain configurations against an arithmetic reference model.
module tb_prueba_i;
    logic               Clk_G = 1'b0;
    logic               Rst_G = 1'b0;
    logic               Rx_En = 1'b0;
    logic signed [12:0] Pot = '0;
    logic signed [12:0] Ref = '0;
    logic signed [25:0] r_a;
    logic signed [25:0] r_b;

`ifdef PRUEBA_I_DEADBAND_EN
    localparam int DB = 2;
`else
    localparam int DB = 0;
`endif
    localparam longint RMAX = 33554431;
    localparam longint RMIN = -33554432;

    int     errors = 0;
    int     checks = 0;
    longint m_a = 0;
    longint m_b = 0;

    prueba_i dut_a (.Clk_G(Clk_G), .Rst_G(Rst_G), .Rx_En(Rx_En), .Pot(Pot), .Ref(Ref), .R_I(r_a));
    prueba_i #(.KI(13'sd3), .KI_SHIFT(2)) dut_b
        (.Clk_G(Clk_G), .Rst_G(Rst_G), .Rx_En(Rx_En), .Pot(Pot), .Ref(Ref), .R_I(r_b));

    always #5 Clk_G = ~Clk_G;

    typedef struct {
        int     rf;
        int     pt;
        longint exp_a;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Integrator step from the rule: r + floor(ki*e / 2^sh), clamped to 26-bit signed range.
    function automatic longint step(input longint r, input longint ki, input int sh, input int e);
        longint p, d, qv, sv;
        int ee;
        ee = ((e <= DB) && (e >= -DB)) ? 0 : e;
        p  = ki * ee;
        d  = longint'(1) << sh;
        qv = p / d;
        if ((p % d != 0) && (p < 0)) qv = qv - 1;
        sv = r + qv;
        if (sv > RMAX) sv = RMAX;
        if (sv < RMIN) sv = RMIN;
        return sv;
    endfunction

    task automatic do_reset();
        @(negedge Clk_G);
        Rst_G = 1'b0;
        Rx_En = 1'b0;
        @(negedge Clk_G);
        Rst_G = 1'b1;
        m_a = 0;
        m_b = 0;
    endtask

    // One sample: capture edge, then 14 edges; inj in 1..13 pulses Rx_En during the busy phase.
    task automatic sample(input int rf, input int pt, input int inj, input bit lat, input bit chk);
        longint old_a;
        @(negedge Clk_G);
        Ref   = 13'(rf);
        Pot   = 13'(pt);
        Rx_En = 1'b1;
        @(posedge Clk_G);
        #1;
        Rx_En = 1'b0;
        Ref   = 13'($urandom);
        Pot   = 13'($urandom);
        old_a = m_a;
        m_a   = step(m_a, 8, 3, rf - pt);
        m_b   = step(m_b, 3, 2, rf - pt);
        for (int k = 1; k <= 14; k++) begin
            if (k == inj) Rx_En = 1'b1;
            @(posedge Clk_G);
            #1;
            Rx_En = 1'b0;
            if (lat && k == 13) check("hold_at_13", longint'(r_a), old_a);
        end
        if (chk) begin
            check("model_a", longint'(r_a), m_a);
            check("model_b", longint'(r_b), m_b);
        end
    endtask

    initial begin
        vec_t vecs[3];
        int   rf, pt, base;

        vecs[0] = '{rf: 270, pt: 0,   exp_a: 270};
        vecs[1] = '{rf: 270, pt: 0,   exp_a: 540};
        vecs[2] = '{rf: 270, pt: 370, exp_a: 440};

        // Reset with live inputs
        Rst_G = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk_G);
            Rx_En = 1'b1;
            Ref   = 13'($urandom);
            Pot   = 13'($urandom);
        end
        check("reset_a", longint'(r_a), 0);
        check("reset_b", longint'(r_b), 0);
        @(negedge Clk_G);
        Rx_En = 1'b0;
        Rst_G = 1'b1;
        repeat (50) @(posedge Clk_G);
        #1;
        check("idle_a", longint'(r_a), 0);

        // Floor of negative products
        sample(0, 1, 0, 1'b0, 1'b1);
        check("floor_a", longint'(r_a), (DB > 0) ? 0 : -1);
        check("floor_b", longint'(r_b), (DB > 0) ? 0 : -1);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            sample(vecs[i].rf, vecs[i].pt, 0, (i == 1), 1'b1);
            check("vec", longint'(r_a), vecs[i].exp_a);
        end

        // Busy: second strobe 5 cycles later must be dropped
        sample(270, 0, 5, 1'b0, 1'b1);
        repeat (20) @(posedge Clk_G);
        #1;
        check("busy_drop", longint'(r_a), 710);

        // Rx_En held high: one calculation per IDLE visit (captures at edges 0 and 15)
        @(negedge Clk_G);
        Ref   = 13'sd100;
        Pot   = 13'sd0;
        Rx_En = 1'b1;
        repeat (16) @(posedge Clk_G);
        #1;
        Rx_En = 1'b0;
        repeat (14) @(posedge Clk_G);
        #1;
        m_a = step(step(m_a, 8, 3, 100), 8, 3, 100);
        m_b = step(step(m_b, 3, 2, 100), 3, 2, 100);
        check("held_a", longint'(r_a), 910);
        check("held_b", longint'(r_b), m_b);
        repeat (20) @(posedge Clk_G);
        #1;
        check("held_quiet", longint'(r_a), m_a);

        // Abort: reset at capture edge + 7
        @(negedge Clk_G);
        Ref   = 13'sd500;
        Rx_En = 1'b1;
        @(posedge Clk_G);
        #1;
        Rx_En = 1'b0;
        repeat (7) @(posedge Clk_G);
        #2;
        Rst_G = 1'b0;
        #1;
        check("abort_zero", longint'(r_a), 0);
        @(negedge Clk_G);
        Rst_G = 1'b1;
        m_a = 0;
        m_b = 0;
        repeat (30) @(posedge Clk_G);
        #1;
        check("abort_quiet", longint'(r_a), 0);

        // Deadband boundary
        do_reset();
        sample(270, 0, 0, 1'b0, 1'b0);
        base = int'(r_a);
        sample(270, 268, 0, 1'b0, 1'b1);
        check("db_edge", longint'(r_a), longint'(base + ((DB > 0) ? 0 : 2)));
        base = int'(r_a);
        sample(270, 267, 0, 1'b0, 1'b1);
        check("db_out", longint'(r_a), longint'(base + 3));

        // Randomized samples, with stray strobes while busy
        do_reset();
        for (int i = 0; i < 150; i++) begin
            if (i % 3 == 0) begin
                rf = int'($urandom_range(20)) - 10;
                pt = int'($urandom_range(20)) - 10;
            end else begin
                rf = int'($urandom_range(8191)) - 4096;
                pt = int'($urandom_range(8191)) - 4096;
            end
            sample(rf, pt, ($urandom_range(1) == 1) ? int'($urandom_range(13, 1)) : 0, 1'b0, 1'b1);
        end

        // Saturation and unwind
        do_reset();
        for (int i = 0; i < 4096; i++)
            sample(4095, -4096, 0, 1'b0, (i % 512 == 0));
        check("sat_4096", longint'(r_a), 33550336);
        sample(4095, -4096, 0, 1'b0, 1'b1);
        check("sat_clamp", longint'(r_a), RMAX);
        sample(4095, -4096, 0, 1'b0, 1'b1);
        check("sat_stay", longint'(r_a), RMAX);
        sample(-4096, 4095, 0, 1'b0, 1'b1);
        check("sat_unwind", longint'(r_a), 33546240);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prueba_i.md
Name: prueba_i

Overview:
- Integral (I) term of the servo PI controller.
- On each sample strobe it computes error e = Ref - Pot, scales it by a fixed-point gain KI/2^KI_SHIFT and accumulates it into a saturating signed integrator.
- The integrator value is output as R_I.
- It sits between the ADC/receive front end (which pulses Rx_En with each new Pot sample) and the PI summation/PWM stage.

Parameters:
- cant_bits, 13: width of Pot and Ref (signed two's complement).
- KI, 13'sd8: signed integral gain numerator, range -4096..4095.
- KI_SHIFT, 3: arithmetic right shift applied to KI*e (gain = KI/2^KI_SHIFT); range 0..12.
- DEADBAND, 2: error magnitude treated as zero; used only with the optional feature.

Ports:
- Clk_G  in  1  system clock; all state changes on rising edge.
- Rst_G  in  1  reset; asynchronous, active-low.
- Rx_En  in  1  sample strobe; one-cycle high pulse means Pot/Ref are valid.
- Pot  in  13 (cant_bits)  signed measured position.
- Ref  in  13 (cant_bits)  signed setpoint.
- R_I  out  26 (2*cant_bits)  signed registered integrator value.

Behaviour:
- Reset (Rst_G low, asynchronous): R_I=0, internal error/product/counter registers=0, state=IDLE. Reset asserted mid-calculation aborts it; no update occurs after release.
- State machine IDLE -> MUL -> ACC -> IDLE:
  - IDLE: R_I holds. On a rising edge with Rx_En=1 (the capture edge):
    - register e = Ref - Pot, sign-extended to 14 bits (range -8191..8191, no overflow);
    - register |e| and its sign;
    - clear the product register and the iteration counter;
    - go to MUL.
  - MUL: radix-2 shift-add multiplier of |e| (13-bit magnitude) by KI. One bit per edge, 13 edges (capture edge+1 .. +13), then go to ACC.
  - ACC (capture edge+14), in a single edge:
    - restore the sign to form the signed 27-bit product p = KI*e;
    - compute q = p >>> KI_SHIFT (arithmetic, floor toward -inf);
    - compute s = R_I + q in 28 bits;
    - saturate s to [-33554432, 33554431];
    - register into R_I; go to IDLE.
- Latency: R_I takes its new value exactly 14 rising edges after the capture edge and is stable from then until the next update.
- Throughput: one sample per 15 cycles. Rx_En is accepted only in IDLE; pulses in MUL/ACC are ignored (not queued).
- Rx_En held high in IDLE starts one calculation per IDLE visit.
- Pot/Ref are sampled only on the capture edge; later changes do not affect the result in flight.
- Saturation is sticky only in the sense that the integrator stays clamped. Opposite-sign errors unwind it normally (anti-windup by clamping).
- KI=0: R_I never changes. e=0: R_I unchanged after the update.

Optional Feature:
- Macro PRUEBA_I_DEADBAND_EN.
- Defined: on the capture edge, if |Ref-Pot| <= DEADBAND, e is forced to 0. Timing is unchanged (latency 14, R_I rewritten with the same value).
- Undefined: no deadband; every nonzero error is integrated. The DEADBAND parameter is unused.

Test Plan:
- Reset: Rst_G low with arbitrary inputs -> R_I=0. Release, no Rx_En for 50 cycles -> R_I stays 0.
- Default gain, Ref=270, Pot=0. Pulse Rx_En, wait 15 edges -> R_I=270. Second pulse -> R_I=540. R_I must not change at capture edge+13 and must change at +14.
- Negative error: from R_I=540, Ref=270, Pot=370, pulse -> R_I=440. With KI=3, KI_SHIFT=2, Ref=0, Pot=1 from R_I=0 -> q=floor(-3/4)=-1, R_I=-1.
- Saturation: Ref=4095, Pot=-4096, repeated pulses -> +8191 per sample. After 4096 pulses R_I=33550336; pulse 4097 -> R_I=33554431 and it stays there. Then Ref=-4096, Pot=4095 -> R_I=33546240.
- Busy/abort: pulse Rx_En, pulse again 5 cycles later with different Pot -> only the first sample is integrated. A separate run asserts Rst_G at capture edge+7 -> R_I=0 and no later update.
- Deadband (PRUEBA_I_DEADBAND_EN): Ref=270, Pot=268 -> R_I unchanged. Pot=267 -> R_I increases by 3.
